mod12_cnt_ctrl: RTL and testbench
=================================

# mod12_cnt_ctrl

Command sequencer and arbiter for the mod-12 up/down counter. It accepts "load start value, then count N steps up or down" commands from NREQ requesters and grants them round-robin. It drives the counter's load/mode/data_in pins, holds the counter frozen between commands, and returns the final count with the requester ID. It sits between the command sources and the counter instance; the counter's own synchronous reset stays on the system reset.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8.
- STEP_W, 8: width of the step-count field.
- ID_W, max(1,$clog2(NREQ)): derived; requester ID width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_start  in  NREQ*4  packed start values; requester i uses bits [4i+3:4i].
- req_mode  in  NREQ  1 = up, 0 = down.
- req_steps  in  NREQ*STEP_W  packed step counts.
- cnt_load  out  1  to counter load.
- cnt_mode  out  1  to counter mode.
- cnt_data_in  out  4  to counter data_in.
- cnt_data_out  in  4  from counter data_out.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  ID_W  requester that owned the completed command.
- rsp_value  out  4  final counter value.
- rsp_err  out  1  command rejected (range check only).
- busy  out  1  high in any state other than IDLE.

## Operation
- Moore FSM with states IDLE, LOAD, RUN, DONE. Counter pins decode from state and registers only.
- **IDLE:**
  - cnt_load=1 and cnt_data_in=hold_q, which freezes the free-running counter.
  - req_ready[g]=1 only for the arbiter winner g, and only when some req_valid is set.
  - A handshake (valid&ready) latches start, mode, steps and id, then moves to LOAD.
- **LOAD:** cnt_load=1, cnt_data_in=start_q, cnt_mode=mode_q. Go to RUN if steps_q≠0, else DONE.
- **RUN:**
  - cnt_load=0, cnt_mode=mode_q.
  - rem_q counts from steps_q down to 1. Leave for DONE on the cycle rem_q==1.
- **DONE:**
  - rsp_valid=1, rsp_value=cnt_data_out, rsp_id=id_q.
  - cnt_load=1, cnt_data_in=cnt_data_out (hold).
  - hold_q<=cnt_data_out, then back to IDLE.
- **Arbitration:**
  - Round-robin pointer ptr_q, reset 0. The winner is the first valid requester at or after ptr_q, searching cyclically.
  - After a grant to i, ptr_q<=(i+1) mod NREQ.
  - req_ready depends combinationally on req_valid, so requesters must not gate valid on ready.
- **Result:** (start ± steps) mod 12, with wrap 11→0 going up and 0→11 going down. The counter does the arithmetic; the controller only counts cycles.
- **Reset values:**
  - state=IDLE, hold_q=0, ptr_q=0.
  - cnt_load=1, cnt_data_in=0, cnt_mode=0.
  - rsp_valid=0, rsp_id=0, rsp_value=0, rsp_err=0, busy=0.
  - req_ready=0 while reset is asserted.
- **Reset mid-command:** the command is dropped with no rsp_valid. Requesters must reissue it.

## Timing
- Handshake in cycle 0. LOAD in cycle 1; the counter holds start after that edge. RUN in cycles 2..steps+1. DONE, and therefore rsp_valid, in cycle steps+2.
- steps=0 gives rsp_valid in cycle 2 with rsp_value=start.
- The earliest next handshake is cycle steps+3. One command is in flight at a time.
- Maximum steps is 2^STEP_W−1. No saturation or overflow logic is required.

## Configuration
- CNT_CTRL_RANGE_CHK_EN:
  - **Defined:** a start value above 11 is accepted and then rejected. The FSM goes IDLE→DONE directly with rsp_err=1 and rsp_value=hold_q. The counter stays held and hold_q is unchanged. Response comes in cycle 1.
  - **Undefined:** rsp_err is tied 0. The start value is loaded unchecked; counter behaviour above 11 is the counter's own.

## Structure
- Package mod12_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - localparams MOD=12, MAX_VAL=4'd11, CNT_W=4.
- Sub-module rr_arbiter: parameter N; inputs req, advance; outputs one-hot grant and grant index. It owns ptr_q.

## Test plan
- Requester 0: start=10, up, steps=3 → rsp_valid in cycle 5, rsp_value=1, rsp_id=0. cnt_data_out stays at 1 for 20 idle cycles afterwards.
- Requester 1: start=1, down, steps=3 → counter sequence 1,0,11,10; rsp_value=10, rsp_id=1.
- start=7, steps=0 → rsp_valid in cycle 2, rsp_value=7, counter never leaves 7.
- Both requesters hold valid continuously from reset → grant order 0,1,0,1. Every grant is followed by its own response before the next handshake.
- start=13:
  - With the macro defined → rsp_err=1 in cycle 1, rsp_value equals the previous result, counter unchanged.
  - Without the macro → rsp_err=0 and the counter loads 13.
- Reset asserted in RUN with steps=50 → all outputs reach reset values immediately and no rsp_valid pulses. A following command (start=4, up, steps=2) returns 6.

Source files
------------

// File: rtl/mod12_ctrl_pkg.sv
// Shared types and constants for the mod-12 counter command sequencer.
package mod12_ctrl_pkg;

  localparam int         MOD     = 12;
  localparam logic [3:0] MAX_VAL = 4'd11;
  localparam int         CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic in_range(input logic [CNT_W-1:0] v);
    return v <= MAX_VAL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_q wins; ptr_q moves past
// the winner only when the grant is consumed (advance).
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : IDX_W'(int'(grant_idx) + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mod12_cnt_ctrl.sv
// Command sequencer/arbiter in front of the mod-12 up/down counter.
// Optional start-value range check: define CNT_CTRL_RANGE_CHK_EN.
module mod12_cnt_ctrl
  import mod12_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int STEP_W = 8,
  parameter int ID_W   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*4-1:0]      req_start,
  input  logic [NREQ-1:0]        req_mode,
  input  logic [NREQ*STEP_W-1:0] req_steps,
  output logic                   cnt_load,
  output logic                   cnt_mode,
  output logic [3:0]             cnt_data_in,
  input  logic [3:0]             cnt_data_out,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [3:0]             rsp_value,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

`ifdef CNT_CTRL_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  // Handshake: a command transfers on a cycle where req_valid[i] & req_ready[i].
  // req_ready is combinational from req_valid, so valid must not wait on ready.

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    start_q, start_d;
  logic                mode_q, mode_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic                err_q, err_d;

  logic [NREQ-1:0]     gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                hs;
  logic [CNT_W-1:0]    sel_start;
  logic [STEP_W-1:0]   sel_steps;
  logic                sel_mode;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (req_valid),
    .advance   (hs),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign req_ready = (state_q == IDLE && !reset) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);
  assign sel_start = req_start[4*int'(gnt_idx) +: 4];
  assign sel_steps = req_steps[STEP_W*int'(gnt_idx) +: STEP_W];
  assign sel_mode  = req_mode[gnt_idx];
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    mode_d      = mode_q;
    rem_d       = rem_q;
    id_d        = id_q;
    hold_d      = hold_q;
    err_d       = err_q;
    cnt_load    = 1'b1;
    cnt_mode    = 1'b0;
    cnt_data_in = hold_q;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_value   = '0;
    rsp_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          start_d = sel_start;
          mode_d  = sel_mode;
          rem_d   = sel_steps;
          id_d    = gnt_idx;
          err_d   = RANGE_CHK && !in_range(sel_start);
          // A rejected command skips the counter entirely and answers next cycle.
          state_d = (RANGE_CHK && !in_range(sel_start)) ? DONE : LOAD;
        end
      end
      LOAD: begin
        cnt_data_in = start_q;
        cnt_mode    = mode_q;
        state_d     = (rem_q != '0) ? RUN : DONE;
      end
      RUN: begin
        cnt_load = 1'b0;
        cnt_mode = mode_q;
        if (rem_q == STEP_W'(1)) state_d = DONE;
        else                     rem_d   = rem_q - STEP_W'(1);
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_err   = err_q;
        state_d   = IDLE;
        if (err_q) begin
          rsp_value   = hold_q;
          cnt_data_in = hold_q;
        end else begin
          rsp_value   = cnt_data_out;
          cnt_data_in = cnt_data_out;
          hold_d      = cnt_data_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= '0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mod12_cnt_ctrl.sv
// Bench for mod12_cnt_ctrl with a behavioural mod-12 counter attached.
module tb_mod12_cnt_ctrl;

  localparam int NREQ   = 2;
  localparam int STEP_W = 8;
  localparam int ID_W   = 1;

`ifdef CNT_CTRL_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid, req_ready, req_mode;
  logic [NREQ*4-1:0]      req_start;
  logic [NREQ*STEP_W-1:0] req_steps;
  logic                   cnt_load, cnt_mode;
  logic [3:0]             cnt_data_in, cnt_data_out;
  logic                   rsp_valid, rsp_err, busy;
  logic [ID_W-1:0]        rsp_id;
  logic [3:0]             rsp_value;
  logic [1:0]             dbg_state;

  always #5 clk = ~clk;

  mod12_cnt_ctrl #(.NREQ(NREQ), .STEP_W(STEP_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_start(req_start),
    .req_mode(req_mode), .req_steps(req_steps),
    .cnt_load(cnt_load), .cnt_mode(cnt_mode), .cnt_data_in(cnt_data_in),
    .cnt_data_out(cnt_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_value(rsp_value),
    .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  // The counter being controlled: synchronous reset, load wins, else count.
  logic [3:0] cnt_q;
  always @(posedge clk) begin
    if (reset)         cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_data_in;
    else if (cnt_mode) cnt_q <= (cnt_q >= 4'd11) ? 4'd0 : cnt_q + 4'd1;
    else               cnt_q <= (cnt_q == 4'd0) ? 4'd11 : cnt_q - 4'd1;
  end
  assign cnt_data_out = cnt_q;

  int n_tests = 0;
  int n_fail  = 0;
  int prev_val = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Value k counter steps after loading st (k=0 is the loaded value itself).
  function automatic int ref_val(input int st, input int md, input int k);
    if (k == 0) return st;
    if (md != 0) return (st + k) % 12;
    return (st + 12 - (k % 12)) % 12;
  endfunction

  task automatic run_cmd(input int id, input int st, input int md, input int stp,
                         input int exp_v_in, input string nm);
    bit         exp_e, got;
    int         exp_lat, exp_v, lat, got_id, got_v, got_e, seq_bad;
    logic [3:0] obs[$];
    exp_e   = CHK && (st > 11);
    exp_lat = exp_e ? 1 : stp + 2;
    exp_v   = exp_e ? prev_val : exp_v_in;
    got_id  = -1; got_v = -1; got_e = -1;
    @(negedge clk);
    req_start[id*4 +: 4]           = 4'(st);
    req_mode[id]                   = md[0];
    req_steps[id*STEP_W +: STEP_W] = STEP_W'(stp);
    req_valid[id]                  = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      #1;
      if (req_ready[id] === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    check({nm, "/ready"}, 32'(req_ready), 32'(1 << id));
    if (!got) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    lat = 0;
    for (int c = 1; c <= stp + 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check({nm, "/busy"}, 32'(busy), 32'd1);
      if (c >= 2) obs.push_back(cnt_q);
      if (rsp_valid === 1'b1) begin
        lat = c; got_id = int'(rsp_id); got_v = int'(rsp_value); got_e = int'(rsp_err);
      end
    end
    check({nm, "/latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "/value"}, 32'(got_v), 32'(exp_v));
    check({nm, "/id"}, 32'(got_id), 32'(id));
    check({nm, "/err"}, 32'(got_e), 32'(exp_e));
    if (!exp_e) begin
      seq_bad = -1;
      if (obs.size() != stp + 1) seq_bad = 1000 + obs.size();
      else
        for (int k = 0; k <= stp; k++)
          if (seq_bad < 0 && obs[k] !== 4'(ref_val(st, md, k))) seq_bad = k;
      check({nm, "/seq_first_bad"}, 32'(seq_bad), 32'hFFFF_FFFF);
      prev_val = exp_v;
    end else begin
      check({nm, "/cnt_unchanged"}, 32'(cnt_q), 32'(prev_val));
    end
  endtask

  task automatic hold_chk(input int n, input int val, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cnt_q !== 4'(val) || busy !== 1'b0) bad++;
    end
    check({nm, "/hold_bad_cycles"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int id; int st; int md; int stp; int exp_v;
  } vec_t;
  vec_t vt[7];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    int n_g, n_r, pulses, bad_order, last_g;
    bit got;

    vt[0] = '{0, 10, 1, 3, 1};
    vt[1] = '{1, 1, 0, 3, 10};
    vt[2] = '{0, 7, 1, 0, 7};
    vt[3] = '{1, 11, 1, 1, 0};
    vt[4] = '{0, 0, 0, 1, 11};
    vt[5] = '{1, 5, 1, 12, 5};
    vt[6] = '{0, 3, 0, 14, 1};

    // Reset state
    reset = 1'b1; req_valid = '0; req_mode = '0; req_start = '0; req_steps = '0;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/cnt_load", 32'(cnt_load), 32'd1);
    check("rst/cnt_data_in", 32'(cnt_data_in), 32'd0);
    check("rst/cnt_mode", 32'(cnt_mode), 32'd0);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/rsp_id", 32'(rsp_id), 32'd0);
    check("rst/rsp_value", 32'(rsp_value), 32'd0);
    check("rst/rsp_err", 32'(rsp_err), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/state", 32'(dbg_state), 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_cmd(vt[i].id, vt[i].st, vt[i].md, vt[i].stp, vt[i].exp_v, $sformatf("vec%0d", i));
      hold_chk((i == 0) ? 20 : 3, vt[i].exp_v, $sformatf("vec%0d", i));
    end

    // Out-of-range start value
    run_cmd(0, 13, 1, 0, 13, "start13");
    hold_chk(3, prev_val, "start13");

    // Randomised commands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      int id, st, md, stp;
      id  = int'($urandom_range(0, NREQ - 1));
      st  = int'($urandom_range(0, 11));
      md  = int'($urandom_range(0, 1));
      stp = int'($urandom_range(0, 30));
      run_cmd(id, st, md, stp, ref_val(st, md, stp), $sformatf("rnd%0d", i));
    end

    // Both requesters valid continuously from reset: grants must alternate
    @(negedge clk);
    reset = 1'b1;
    req_start = {4'd5, 4'd2};
    req_mode  = 2'b01;
    req_steps = {8'd2, 8'd1};
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_g = 0; n_r = 0; last_g = -1; bad_order = 0;
    for (int cyc = 0; cyc < 200 && n_r < 4; cyc++) begin
      #1;
      if ((req_valid & req_ready) != '0) begin
        if (n_g != n_r) bad_order++;
        last_g = (req_ready[1] === 1'b1) ? 1 : 0;
        gq.push_back(last_g);
        n_g++;
      end
      if (rsp_valid === 1'b1) begin
        if (int'(rsp_id) != last_g) bad_order++;
        if (int'(rsp_value) != ((last_g == 0) ? ref_val(2, 1, 1) : ref_val(5, 0, 2))) bad_order++;
        n_r++;
      end
      if (n_r < 4) @(negedge clk);
    end
    req_valid = '0;
    check("rr/responses", 32'(n_r), 32'd4);
    check("rr/grant_rsp_interleave", 32'(bad_order), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("rr/grant%0d", k), (k < gq.size()) ? 32'(gq[k]) : 32'hFFFF_FFFF, 32'(k % 2));

    // Reset in the middle of a long command
    @(negedge clk);
    req_start[3:0] = 4'd0; req_mode[0] = 1'b1; req_steps[7:0] = 8'd50; req_valid[0] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      #1;
      if (req_ready[0] === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    check("midrst/ready", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst/busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/cnt_load", 32'(cnt_load), 32'd1);
    check("midrst/cnt_data_in", 32'(cnt_data_in), 32'd0);
    check("midrst/cnt_mode", 32'(cnt_mode), 32'd0);
    check("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst/rsp_id", 32'(rsp_id), 32'd0);
    check("midrst/rsp_value", 32'(rsp_value), 32'd0);
    check("midrst/rsp_err", 32'(rsp_err), 32'd0);
    check("midrst/req_ready", 32'(req_ready), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) pulses++;
    end
    req_valid = '0;
    reset = 1'b0;
    prev_val = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) pulses++;
    end
    check("midrst/no_rsp", 32'(pulses), 32'd0);
    run_cmd(0, 4, 1, 2, 6, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
